// File: rtl/l2_pkg.sv
// l2_pkg: shared constants, cache mode encodings and arbiter state encoding
package l2_pkg;
  localparam int N_PROC = 4;
  localparam int IDX_W = 2;
  localparam logic [1:0] L2_WRITE = 2'b11;
  localparam logic [1:0] L2_READ = 2'b00;
  localparam logic [1:0] L2_IDLE = 2'b01;
  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE, RECOVER} state_t;
  function automatic logic [N_PROC-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_PROC'(1) << i;
  endfunction
endpackage

// File: rtl/l2_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker, first request at or after rr wins
module rr_pick4
  import l2_pkg::*;
(
  input  logic [N_PROC-1:0] req,
  input  logic [IDX_W-1:0]  rr,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);
  always_comb begin
    valid = |req;
    idx = rr;
    for (int i = N_PROC - 1; i >= 0; i--)
      if (req[IDX_W'(rr + IDX_W'(i))]) idx = IDX_W'(rr + IDX_W'(i));
  end
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin sequencer sharing one L2 cache array among four cores
module l2_arbiter
  import l2_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_PROC-1:0]          req,
  input  logic [N_PROC-1:0]          we,
  input  logic [N_PROC*ADDR_W-1:0]   addr,
  input  logic [N_PROC*DATA_W-1:0]   wdata,
  output logic [N_PROC-1:0]          gnt,
  output logic [N_PROC-1:0]          done,
  output logic [DATA_W-1:0]          rdata,
  output logic [N_PROC-1:0]          inval,
  output logic [DATA_W-1:0]          l2_in,
  input  logic [DATA_W-1:0]          l2_out,
  output logic                       l2_ch,
  output logic [1:0]                 l2_mode,
  output logic [ADDR_W-1:0]          l2_st,
  output logic [IDX_W-1:0]           l2_procinfo,
  input  logic [N_PROC-1:0]          l2_sprocinfo
);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [IDX_W-1:0] rr, widx, pidx;
  logic pvalid, cwe;
  logic [ADDR_W-1:0] caddr;
  logic [DATA_W-1:0] cdata;
  rr_pick4 u_pick (.req(req), .rr(rr), .idx(pidx), .valid(pvalid));
  always_comb begin
    nxt = (state == IDLE) ? (pvalid ? ISSUE : IDLE) :
          (state == ISSUE) ? ((cnt == 4'd0) ? COMPLETE : ISSUE) :
          (state == COMPLETE) ? RECOVER : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // Request fields are frozen at grant; the cache sees only the captured copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      done <= '0;
      inval <= '0;
      rdata <= '0;
      rr <= '0;
      widx <= '0;
      cwe <= 1'b0;
      caddr <= '0;
      cdata <= '0;
      cnt <= '0;
    end else begin
      done <= '0;
      inval <= '0;
      if (state == IDLE && pvalid) begin
        gnt <= onehot(pidx);
        widx <= pidx;
        cwe <= we[pidx];
        caddr <= addr[pidx*ADDR_W +: ADDR_W];
        cdata <= wdata[pidx*DATA_W +: DATA_W];
        cnt <= 4'(ACCESS_CYCLES - 1);
      end
      if (state == ISSUE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (state == COMPLETE) begin
        gnt <= '0;
        done <= onehot(widx);
        inval <= cwe ? (l2_sprocinfo & ~onehot(widx)) : '0;
        rdata <= cwe ? rdata : l2_out;
        rr <= widx + IDX_W'(1);
      end
    end
  end
  assign l2_mode = (state == ISSUE) ? (cwe ? L2_WRITE : L2_READ) : L2_IDLE;
  assign l2_ch = (state != ISSUE);
  assign l2_st = caddr;
  assign l2_in = cdata;
  assign l2_procinfo = widx;
endmodule
